mac_result_collector: RTL

Downstream stage of `top_system`. It watches each MAC lane's `valid_out`/`acc_out_k` pair and captures every new accumulator result once. Each result is requantized (rounding right shift, optional ReLU, saturation to W bits) and queued in a small FIFO. The block streams the queue out over a valid/ready handshake and pulses `layer_done` once all N_MACS lanes have reported.

---
 rtl/mac_result_collector_pkg.sv | 50 +++++
 rtl/mac_result_collector_if.sv | 22 ++
 rtl/mac_result_collector_sync_fifo.sv | 56 +++++
 rtl/mac_result_collector.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mac_result_collector_pkg.sv
// systolic_pkg: shared definitions for the systolic post-processing stages.
//   - default datapath widths (W / ACC_W / N_MACS)
//   - entry_t : one queued result {lane, sat, data} at the default widths
//   - rq_t / requant() : rounding right shift, optional ReLU, saturation
package systolic_pkg;

   localparam int unsigned W_DEF      = 8;
   localparam int unsigned ACC_W_DEF  = 16;
   localparam int unsigned N_MACS_DEF = 4;
   localparam int unsigned LANE_W_DEF = 2;

   typedef struct packed {
      logic [LANE_W_DEF-1:0]   lane;
      logic                    sat;
      logic signed [W_DEF-1:0] data;
   } entry_t;

   typedef struct packed {
      logic               sat;
      logic signed [31:0] val;
   } rq_t;

   // acc must already be sign-extended to 32 bits; with ACC_W <= 31 the
   // rounding add cannot overflow, which matches ACC_W+1-bit evaluation.
   // Caller keeps val[w-1:0]. A ReLU clamp alone never reports sat.
   function automatic rq_t requant(input logic signed [31:0] acc,
                                   input int unsigned shift,
                                   input int unsigned w,
                                   input logic relu);
      logic signed [31:0] r;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      rq_t res;
      r  = (acc + (32'sd1 <<< (shift - 1))) >>> shift;
      if (relu && (r < 0)) r = '0;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      res.sat = 1'b0;
      res.val = r;
      if (r > hi) begin
         res.val = hi;
         res.sat = 1'b1;
      end else if (r < lo) begin
         res.val = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mac_result_collector_if.sv
// Result stream of the collector (FIFO head + valid/ready handshake).
//   out_data  : requantized result, signed
//   out_lane  : source MAC lane
//   out_sat   : entry was saturated
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts the head this cycle
// master = collector side, slave = consumer side.
interface mac_result_collector_if
   import systolic_pkg::*;
#(
   parameter int unsigned W      = W_DEF,
   parameter int unsigned LANE_W = LANE_W_DEF
);
   logic signed [W-1:0] out_data;
   logic [LANE_W-1:0]   out_lane;
   logic                out_sat;
   logic                out_valid;
   logic                out_ready;

   modport master (output out_data, out_lane, out_sat, out_valid, input out_ready);
   modport slave  (input out_data, out_lane, out_sat, out_valid, output out_ready);
endinterface

// File: rtl/mac_result_collector_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two DEPTH.
//   clk, rst_n (sync, active-low), clear (sync flush)
//   wr_en/wr_data : write, ignored while full
//   rd_en/rd_data : read; rd_data shows the head, forced to 0 when empty
//   full, empty, count (occupancy, $clog2(DEPTH)+1 bits)
module sync_fifo
   import systolic_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: captures each new MAC lane result once (rising edge
// of the lane's level valid), requantizes it, queues it and streams it out.
//   clk, rst_n (sync, active-low, wins over clear), clear (sync flush)
//   relu_en     : clamp negative results to 0
//   acc_in      : lane k at [k*ACC_W +: ACC_W], signed
//   valid_in    : per-lane level valid
//   out_if      : result stream (master modport)
//   fifo_count  : FIFO occupancy
//   overrun     : sticky, a capture was dropped because its lane was still pending
//   layer_done  : one-cycle pulse after every lane has pushed at least once
module mac_result_collector
   import systolic_pkg::*;
#(
   parameter int unsigned W      = W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned N_MACS = N_MACS_DEF,
   parameter int unsigned SHIFT  = 4,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      relu_en,
   input  logic [N_MACS*ACC_W-1:0]   acc_in,
   input  logic [N_MACS-1:0]         valid_in,
   mac_result_collector_if.master    out_if,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      overrun,
   output logic                      layer_done
);
   localparam int unsigned LANE_W = (N_MACS > 1) ? $clog2(N_MACS) : 1;
   localparam int unsigned E_W    = LANE_W + 1 + W;

   logic [N_MACS-1:0] valid_q;
   logic [N_MACS-1:0] cap;
   logic [N_MACS-1:0] pending;
   logic [N_MACS-1:0] seen;
   logic [W-1:0]      hold_data [N_MACS];
   logic [N_MACS-1:0] hold_sat;

   rq_t               rq_res  [N_MACS];
   logic [W-1:0]      rq_data [N_MACS];
   logic [N_MACS-1:0] rq_sat;

   logic              sel_valid;
   logic [LANE_W-1:0] sel_lane;
   logic [N_MACS-1:0] sel_mask;
   logic              push;
   logic [N_MACS-1:0] push_mask;

   logic              fifo_full;
   logic              fifo_empty;
   logic [E_W-1:0]    wr_entry;
   logic [E_W-1:0]    rd_entry;
   logic              pop;

   assign cap = valid_in & ~valid_q;

   always_comb begin
      for (int unsigned k = 0; k < N_MACS; k++) begin
         rq_res[k]  = requant(32'(signed'(acc_in[k*ACC_W +: ACC_W])), SHIFT, W, relu_en);
         rq_data[k] = rq_res[k].val[W-1:0];
         rq_sat[k]  = rq_res[k].sat;
      end
   end

   // Fixed-priority arbiter: lowest pending lane wins; nothing leaves while full.
   always_comb begin
      sel_valid = 1'b0;
      sel_lane  = '0;
      sel_mask  = '0;
      for (int unsigned k = 0; k < N_MACS; k++) begin
         if (pending[k] && !sel_valid) begin
            sel_valid   = 1'b1;
            sel_lane    = LANE_W'(k);
            sel_mask[k] = 1'b1;
         end
      end
      push      = sel_valid & ~fifo_full & ~clear;
      push_mask = push ? sel_mask : '0;
   end

   assign wr_entry = {sel_lane, hold_sat[sel_lane], hold_data[sel_lane]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         pending    <= '0;
         seen       <= '0;
         overrun    <= 1'b0;
         layer_done <= 1'b0;
         hold_sat   <= '0;
         for (int unsigned k = 0; k < N_MACS; k++) hold_data[k] <= '0;
      end else begin
         valid_q <= valid_in;
         if (clear) begin
            pending    <= '0;
            seen       <= '0;
            overrun    <= 1'b0;
            layer_done <= 1'b0;
         end else begin
            // A lane being pushed this cycle hands its old hold to the FIFO,
            // so it may accept a new capture without counting as overrun.
            for (int unsigned k = 0; k < N_MACS; k++) begin
               if (cap[k]) begin
                  if (pending[k] && !push_mask[k]) begin
                     overrun <= 1'b1;
                  end else begin
                     hold_data[k] <= rq_data[k];
                     hold_sat[k]  <= rq_sat[k];
                  end
               end
            end
            pending    <= (pending & ~push_mask) | cap;
            layer_done <= &seen;
            seen       <= ((&seen) ? '0 : seen) | push_mask;
         end
      end
   end

   sync_fifo #(
      .WIDTH (E_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .wr_en   (push),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign pop              = out_if.out_valid & out_if.out_ready;
   assign out_if.out_valid = ~fifo_empty;
   assign {out_if.out_lane, out_if.out_sat, out_if.out_data} = rd_entry;
endmodule
